// File: rtl/camera_capture_ctrl.sv
// Frame capture sequencer: arms the camera trigger, counts lines, detects
// end of frame by a quiet gap on line_active, and reports completion/errors.
module camera_capture_ctrl #(
  parameter int LINES_PER_FRAME = 240,
  parameter int EOF_GAP         = 2000,
  parameter int ARM_TIMEOUT     = 5000000,
  parameter int LINE_W          = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        num_frames,
  input  logic              line_active,
  output logic              trigger,
  output logic              busy,
  output logic              frame_done,
  output logic              capture_done,
  output logic [LINE_W-1:0] line_count,
  output logic [7:0]        frames_left,
  output logic              err_timeout,
  output logic              err_lines
);

  localparam int                GAP_W     = $clog2(EOF_GAP + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(EOF_GAP - 1);
  localparam logic [23:0]       ARM_LAST  = 24'(ARM_TIMEOUT - 1);
  localparam logic [LINE_W-1:0] LINES_EXP = LINE_W'(LINES_PER_FRAME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_FRAME_END
  } state_t;

  state_t            r_state;
  logic              r_line_active_d;
  logic [23:0]       r_arm_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [LINE_W-1:0] r_line_count;
  logic [7:0]        r_frames_left;
  logic              r_trigger;
  logic              r_frame_done;
  logic              r_capture_done;
  logic              r_err_timeout;
  logic              r_err_lines;

  state_t            w_state_nxt;
  logic              w_rise;
  logic [23:0]       w_arm_cnt_nxt;
  logic [GAP_W-1:0]  w_gap_cnt_nxt;
  logic [LINE_W-1:0] w_line_count_nxt;
  logic [7:0]        w_frames_left_nxt;
  logic [7:0]        w_frames_dec;
  logic              w_frame_done_nxt;
  logic              w_capture_done_nxt;
  logic              w_err_timeout_nxt;
  logic              w_err_lines_nxt;

  assign w_rise       = line_active & ~r_line_active_d;
  assign w_frames_dec = r_frames_left - 8'd1;

  always_comb begin
    w_state_nxt        = r_state;
    w_arm_cnt_nxt      = r_arm_cnt;
    w_gap_cnt_nxt      = r_gap_cnt;
    w_line_count_nxt   = r_line_count;
    w_frames_left_nxt  = r_frames_left;
    w_frame_done_nxt   = 1'b0;
    w_capture_done_nxt = 1'b0;
    w_err_timeout_nxt  = r_err_timeout;
    w_err_lines_nxt    = r_err_lines;

    // Abort outranks every other event; in IDLE it also swallows a start.
    if (abort) begin
      if (r_state != S_IDLE) begin
        w_state_nxt        = S_IDLE;
        w_capture_done_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_frames_left_nxt = (num_frames == 8'd0) ? 8'd1 : num_frames;
            w_line_count_nxt  = '0;
            w_err_timeout_nxt = 1'b0;
            w_err_lines_nxt   = 1'b0;
            w_arm_cnt_nxt     = '0;
            w_state_nxt       = S_ARM;
          end
        end
        S_ARM: begin
          if (w_rise) begin
            w_line_count_nxt = LINE_W'(1);
            w_gap_cnt_nxt    = '0;
            w_state_nxt      = S_CAPTURE;
          end else if (r_arm_cnt == ARM_LAST) begin
            w_err_timeout_nxt  = 1'b1;
            w_capture_done_nxt = 1'b1;
            w_state_nxt        = S_IDLE;
          end else begin
            w_arm_cnt_nxt = r_arm_cnt + 24'd1;
          end
        end
        S_CAPTURE: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = S_FRAME_END;
          end else if (w_rise) begin
            if (r_line_count != '1) begin
              w_line_count_nxt = r_line_count + 1'b1;
            end
            w_gap_cnt_nxt = '0;
          end else if (!line_active) begin
            w_gap_cnt_nxt = r_gap_cnt + 1'b1;
          end else begin
            w_gap_cnt_nxt = '0;
          end
        end
        S_FRAME_END: begin
          w_frame_done_nxt  = 1'b1;
          w_frames_left_nxt = w_frames_dec;
          if (r_line_count != LINES_EXP) begin
            w_err_lines_nxt = 1'b1;
          end
          if (w_frames_dec == 8'd0) begin
            w_capture_done_nxt = 1'b1;
            w_state_nxt        = S_IDLE;
          end else begin
            w_arm_cnt_nxt = '0;
            w_state_nxt   = S_ARM;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_line_active_d <= 1'b0;
      r_arm_cnt       <= '0;
      r_gap_cnt       <= '0;
      r_line_count    <= '0;
      r_frames_left   <= '0;
      r_trigger       <= 1'b0;
      r_frame_done    <= 1'b0;
      r_capture_done  <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_err_lines     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_line_active_d <= line_active;
      r_arm_cnt       <= w_arm_cnt_nxt;
      r_gap_cnt       <= w_gap_cnt_nxt;
      r_line_count    <= w_line_count_nxt;
      r_frames_left   <= w_frames_left_nxt;
      // Trigger follows the registered state so it is high exactly while armed.
      r_trigger       <= (w_state_nxt == S_ARM);
      r_frame_done    <= w_frame_done_nxt;
      r_capture_done  <= w_capture_done_nxt;
      r_err_timeout   <= w_err_timeout_nxt;
      r_err_lines     <= w_err_lines_nxt;
    end
  end

  assign trigger      = r_trigger;
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = r_frame_done;
  assign capture_done = r_capture_done;
  assign line_count   = r_line_count;
  assign frames_left  = r_frames_left;
  assign err_timeout  = r_err_timeout;
  assign err_lines    = r_err_lines;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Bench for camera_capture_ctrl: table-driven captures with a frame scoreboard,
// plus directed timeout, abort, reset and start-collision sequences.
`timescale 1ns/1ps
module tb_camera_capture_ctrl;

  localparam int LPF     = 8;
  localparam int GAP     = 20;
  localparam int ATO     = 1000;
  localparam int LW      = 4;
  localparam int HI_CYC  = 6;
  localparam int LO_CYC  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    num_frames = 8'd0;
  logic          line_active = 1'b0;
  logic          trigger, busy, frame_done, capture_done;
  logic [LW-1:0] line_count;
  logic [7:0]    frames_left;
  logic          err_timeout, err_lines;

  camera_capture_ctrl #(
    .LINES_PER_FRAME(LPF),
    .EOF_GAP(GAP),
    .ARM_TIMEOUT(ATO),
    .LINE_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_frames(num_frames), .line_active(line_active),
    .trigger(trigger), .busy(busy), .frame_done(frame_done),
    .capture_done(capture_done), .line_count(line_count),
    .frames_left(frames_left), .err_timeout(err_timeout), .err_lines(err_lines)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int lc;
    int fl;
    bit err;
    bit cap;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  typedef struct {
    int nf;
    int lines;
    bit exp_err;
    int exp_lc;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every frame_done must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (q.size() == 0) begin
        chk("unexpected_frame_done", 1, 0);
      end else begin
        m_e = q.pop_front();
        chk("sb_line_count", int'(line_count), m_e.lc);
        chk("sb_frames_left", int'(frames_left), m_e.fl);
        chk("sb_err_lines", int'(err_lines), int'(m_e.err));
        chk("sb_capture_done", int'(capture_done), int'(m_e.cap));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int nf);
    num_frames = 8'(nf);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_trigger();
    int n = 0;
    while (trigger !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("trigger_armed", int'(trigger), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_trigger"}, int'(trigger), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_capture_done"}, int'(capture_done), 0);
    chk({tag, "_line_count"}, int'(line_count), 0);
    chk({tag, "_frames_left"}, int'(frames_left), 0);
    chk({tag, "_err_timeout"}, int'(err_timeout), 0);
    chk({tag, "_err_lines"}, int'(err_lines), 0);
  endtask

  task automatic drive_lines(input int lines, input bit last_is_eof);
    for (int l = 0; l < lines; l++) begin
      line_active = 1'b1;
      for (int c = 0; c < HI_CYC; c++) begin
        tick();
        if (l == 0 && c == 0) chk("trigger_drop_on_rise", int'(trigger), 0);
      end
      line_active = 1'b0;
      if (!(last_is_eof && l == lines - 1)) repeat (LO_CYC) tick();
    end
  endtask

  task automatic run_capture(input vec_t v);
    int  exp_nf;
    int  n;
    exp_t e;
    exp_nf = (v.nf == 0) ? 1 : v.nf;
    do_start(v.nf);
    chk("start_frames_left", int'(frames_left), exp_nf);
    chk("start_busy", int'(busy), 1);
    chk("start_err_lines_clr", int'(err_lines), 0);
    chk("start_err_timeout_clr", int'(err_timeout), 0);
    for (int f = 0; f < exp_nf; f++) begin
      wait_trigger();
      e.lc  = v.exp_lc;
      e.fl  = exp_nf - f - 1;
      e.err = v.exp_err;
      e.cap = (f == exp_nf - 1);
      q.push_back(e);
      drive_lines(v.lines, 1'b1);
      n = 0;
      while (frame_done !== 1'b1 && n < GAP + 50) begin
        tick();
        n++;
      end
      chk("eof_latency", n, GAP + 1);
    end
    tick();
    tick();
    chk("end_busy", int'(busy), 0);
    chk("end_trigger", int'(trigger), 0);
    chk("end_frames_left", int'(frames_left), 0);
    chk("end_line_count_held", int'(line_count), v.exp_lc);
    chk("end_err_lines", int'(err_lines), int'(v.exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{nf: 1, lines: LPF,     exp_err: 1'b0, exp_lc: LPF};
    tbl[1] = '{nf: 3, lines: LPF,     exp_err: 1'b0, exp_lc: LPF};
    tbl[2] = '{nf: 0, lines: LPF,     exp_err: 1'b0, exp_lc: LPF};
    tbl[3] = '{nf: 1, lines: LPF - 1, exp_err: 1'b1, exp_lc: LPF - 1};
    tbl[4] = '{nf: 2, lines: LPF + 1, exp_err: 1'b1, exp_lc: LPF + 1};
    tbl[5] = '{nf: 1, lines: 20,      exp_err: 1'b1, exp_lc: 15};

    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run_capture(tbl[i]);

    // Arm timeout with no line activity.
    do_start(1);
    n = 0;
    while (capture_done !== 1'b1 && n < 2 * ATO) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, ATO);
    chk("timeout_err", int'(err_timeout), 1);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_trigger", int'(trigger), 0);
    tick();
    chk("timeout_pulse_width", int'(capture_done), 0);

    // Abort on the same cycle as the fifth rise.
    do_start(2);
    chk("abort_prior_err_timeout_clr", int'(err_timeout), 0);
    wait_trigger();
    drive_lines(4, 1'b0);
    line_active = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    line_active = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_trigger", int'(trigger), 0);
    chk("abort_line_count", int'(line_count), 4);
    chk("abort_capture_done", int'(capture_done), 1);
    chk("abort_frames_left", int'(frames_left), 2);
    chk("abort_frame_done", int'(frame_done), 0);
    tick();
    chk("abort_pulse_width", int'(capture_done), 0);
    repeat (GAP + 5) tick();

    // Start while busy is ignored, then a one-cycle reset mid-ARM.
    do_start(3);
    repeat (5) tick();
    num_frames = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", int'(frames_left), 3);
    chk("busy_start_trigger", int'(trigger), 1);
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_arm_reset");
    rst_n = 1'b1;
    tick();

    // Start and abort together in IDLE: abort wins silently.
    num_frames = 8'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_capture_done", int'(capture_done), 0);
    chk("idle_abort_frames_left", int'(frames_left), 0);
    repeat (3) tick();

    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
